// File: rtl/rename_pkg.sv
// Shared rename-stage definitions: the physical-register index width, the lane count,
// the lane type, and the two-lane round-robin pick used by allocators.
package rename_pkg;

    localparam int PREG_W = 5;
    localparam int NLANE  = 2;

    typedef enum logic {
        LANE0 = 1'b0,
        LANE1 = 1'b1
    } lane_e;

    // One-hot-or-zero pick among the requesting lanes. When both lanes request, the
    // prio lane wins. A lone requester always wins.
    function automatic logic [NLANE-1:0] rr_pick(input logic [NLANE-1:0] req,
                                                 input lane_e            prio);
        logic [NLANE-1:0] pick;
        pick = '0;
        case (req)
            2'b01:   pick = 2'b01;
            2'b10:   pick = 2'b10;
            2'b11:   pick = (prio == LANE1) ? 2'b10 : 2'b01;
            default: pick = '0;
        endcase
        return pick;
    endfunction

endpackage

// File: rtl/rel_buf.sv
// Release staging buffer: a circular buffer that accepts up to two writes per cycle
// (port 0 ahead of port 1) and drains one entry per cycle. The head is read
// combinationally. The pointers wrap naturally because N is a power of two. The
// caller only writes when at least two slots are free, and only reads when the
// buffer is non-empty.
module rel_buf #(
    parameter int W  = 5,
    parameter int N  = 4,
    localparam int AW = $clog2(N)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [1:0]    wr_en,
    input  logic [W-1:0]  wr_data0,
    input  logic [W-1:0]  wr_data1,
    input  logic          rd_en,
    output logic [W-1:0]  rd_data,
    output logic [AW:0]   occ
);

    logic [W-1:0]  mem [N];
    logic [AW-1:0] wptr_reg;
    logic [AW-1:0] rptr_reg;
    logic [AW:0]   occ_reg;
    logic [AW-1:0] wr_addr1;
    logic [AW:0]   push_cnt;

    // Port 1 lands directly behind port 0 when both are writing. Otherwise it takes
    // the tail slot itself.
    always_comb begin
        wr_addr1 = wptr_reg + AW'(wr_en[0]);
        push_cnt = (AW+1)'(wr_en[0]) + (AW+1)'(wr_en[1]);
    end

    // Storage array. The contents need no reset because occupancy marks what is valid.
    always_ff @(posedge i_clk) begin
        if (wr_en[0]) mem[wptr_reg] <= wr_data0;
        if (wr_en[1]) mem[wr_addr1] <= wr_data1;
    end

    // Pointer and occupancy bookkeeping. A buffered release is discarded on reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wptr_reg <= '0;
            rptr_reg <= '0;
            occ_reg  <= '0;
        end else begin
            wptr_reg <= wptr_reg + push_cnt[AW-1:0];
            if (rd_en) rptr_reg <= rptr_reg + AW'(1);
            occ_reg  <= occ_reg + push_cnt - (AW+1)'(rd_en);
        end
    end

    assign rd_data = mem[rptr_reg];
    assign occ     = occ_reg;

endmodule

// File: rtl/preg_alloc_ctrl.sv
// Physical-register allocation controller. This block does the following:
// - It grants free registers to two rename lanes, round-robin, one per cycle.
// - It stages committed releases in rel_buf.
// - It drains those releases into an external free list, one per cycle.
// It also tracks the occupancy of the free list.
// Optional macro PREG_ALLOC_BYPASS_EN: when the list is empty but a release is
// staged, the release is handed straight to a requester.
module preg_alloc_ctrl
    import rename_pkg::*;
#(
    parameter int WIDTH = PREG_W,
    parameter int DEPTH = 31,
    parameter int RBUF  = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [NLANE-1:0]  i_req,
    output logic [NLANE-1:0]  o_gnt,
    output logic [WIDTH-1:0]  o_preg,
    input  logic [NLANE-1:0]  i_rel_vld,
    input  logic [WIDTH-1:0]  i_rel_preg0,
    input  logic [WIDTH-1:0]  i_rel_preg1,
    output logic              o_rel_rdy,
    output logic              o_fl_re,
    output logic              o_fl_we,
    output logic [WIDTH-1:0]  o_fl_wdata,
    input  logic [WIDTH-1:0]  i_fl_rdata,
    output logic [WIDTH:0]    o_count,
    output logic              o_empty,
    output logic              o_ovf
);

    localparam int BAW = $clog2(RBUF);
    localparam logic [WIDTH:0] DEPTH_C   = (WIDTH+1)'(DEPTH);
    localparam logic [BAW:0]   RDY_LIMIT = (BAW+1)'(RBUF - 2);

    logic [WIDTH:0]   count_reg;
    lane_e            ptr_reg;
    logic             ovf_reg;

    logic [WIDTH-1:0] buf_head;
    logic [BAW:0]     buf_occ;
    logic             buf_empty;
    logic [1:0]       buf_push;
    logic             buf_pop;

    logic             list_avail;
    logic             bypass_avail;
    logic             bypass_gnt;
    logic [NLANE-1:0] gnt;

    rel_buf #(
        .W (WIDTH),
        .N (RBUF)
    ) u_rel_buf (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .wr_en    (buf_push),
        .wr_data0 (i_rel_preg0),
        .wr_data1 (i_rel_preg1),
        .rd_en    (buf_pop),
        .rd_data  (buf_head),
        .occ      (buf_occ)
    );

    assign buf_empty  = (buf_occ == '0);
    assign list_avail = (count_reg != '0);

`ifdef PREG_ALLOC_BYPASS_EN
    assign bypass_avail = !list_avail && !buf_empty;
`else
    assign bypass_avail = 1'b0;
`endif

    // Grant, free-list read/write strobes, and staging push/pop. A register written
    // this cycle is not visible to the grant until the list count includes it.
    always_comb begin
        gnt        = '0;
        if (i_rst_n && (list_avail || bypass_avail))
            gnt = rr_pick(i_req, ptr_reg);
        bypass_gnt = (gnt != '0) && !list_avail;
        o_gnt      = gnt;
        o_fl_re    = (gnt != '0) && list_avail;
        o_preg     = bypass_gnt ? buf_head : i_fl_rdata;
        o_fl_we    = i_rst_n && !buf_empty && (count_reg < DEPTH_C) && !bypass_gnt;
        o_fl_wdata = buf_head;
        o_rel_rdy  = (buf_occ <= RDY_LIMIT);
        buf_pop    = o_fl_we || bypass_gnt;
        buf_push   = o_rel_rdy ? i_rel_vld : 2'b00;
    end

    // Occupancy counter, round-robin pointer, and sticky release-overflow flag.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count_reg <= DEPTH_C;
            ptr_reg   <= LANE0;
            ovf_reg   <= 1'b0;
        end else begin
            count_reg <= count_reg + (WIDTH+1)'(o_fl_we) - (WIDTH+1)'(o_fl_re);
            if (gnt != '0)
                ptr_reg <= (ptr_reg == LANE0) ? LANE1 : LANE0;
            if (!o_rel_rdy && (i_rel_vld != '0))
                ovf_reg <= 1'b1;
        end
    end

    assign o_count = count_reg;
    assign o_empty = (count_reg == '0);
    assign o_ovf   = ovf_reg;

endmodule

// File: tb/tb_preg_alloc_ctrl.sv
// Bench for preg_alloc_ctrl. The model keeps the free list and the staging buffer
// as queues, and is checked against the DUT on every falling edge. Directed steps
// add literal expectations for the documented scenarios.
module tb_preg_alloc_ctrl;
    localparam int W     = 5;
    localparam int DEPTH = 31;
    localparam int RBUF  = 4;
`ifdef PREG_ALLOC_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic         i_clk = 1'b0;
    logic         i_rst_n;
    logic [1:0]   i_req, i_rel_vld, o_gnt;
    logic [W-1:0] o_preg, i_rel_preg0, i_rel_preg1, o_fl_wdata, i_fl_rdata;
    logic         o_rel_rdy, o_fl_re, o_fl_we, o_empty, o_ovf;
    logic [W:0]   o_count;

    int checks = 0;
    int errors = 0;

    preg_alloc_ctrl #(.WIDTH(W), .DEPTH(DEPTH), .RBUF(RBUF)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req(i_req), .o_gnt(o_gnt), .o_preg(o_preg),
        .i_rel_vld(i_rel_vld), .i_rel_preg0(i_rel_preg0), .i_rel_preg1(i_rel_preg1),
        .o_rel_rdy(o_rel_rdy), .o_fl_re(o_fl_re), .o_fl_we(o_fl_we), .o_fl_wdata(o_fl_wdata),
        .i_fl_rdata(i_fl_rdata), .o_count(o_count), .o_empty(o_empty), .o_ovf(o_ovf)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int   m_cnt;
    int   m_q[$];     // staged releases, oldest first
    int   m_fl[$];    // contents of the external free list, head first
    bit   m_ptr;      // lane that wins a tie
    bit   m_ovf;
    logic [1:0] e_gnt;
    bit   e_re, e_we, e_byp, e_rdy;

    function automatic void model_reset();
        m_cnt = DEPTH;
        m_q.delete();
        m_fl.delete();
        for (int i = 1; i <= DEPTH; i++) m_fl.push_back(i);
        m_ptr = 1'b0;
        m_ovf = 1'b0;
        e_gnt = 2'b00; e_re = 0; e_we = 0; e_byp = 0; e_rdy = 1;
    endfunction

    initial model_reset();

    // Compare process: derive this cycle's expected outputs and check them.
    always @(negedge i_clk) begin
        int  lane;
        bit  can;
        if (!i_rst_n) begin
            model_reset();
        end else begin
            can   = (m_cnt > 0) || (BYP && m_cnt == 0 && m_q.size() > 0);
            lane  = -1;
            if (can && i_req == 2'b11) lane = m_ptr ? 1 : 0;
            else if (can && i_req == 2'b01) lane = 0;
            else if (can && i_req == 2'b10) lane = 1;
            e_gnt = (lane < 0) ? 2'b00 : ((lane == 1) ? 2'b10 : 2'b01);
            e_re  = (lane >= 0) && (m_cnt > 0);
            e_byp = (lane >= 0) && (m_cnt == 0);
            e_we  = (m_q.size() > 0) && (m_cnt < DEPTH) && !e_byp;
            e_rdy = (RBUF - m_q.size()) >= 2;
        end
        chk("gnt",     o_gnt,     e_gnt);
        chk("fl_re",   o_fl_re,   e_re);
        chk("fl_we",   o_fl_we,   e_we);
        chk("count",   o_count,   m_cnt);
        chk("empty",   o_empty,   m_cnt == 0);
        chk("rel_rdy", o_rel_rdy, e_rdy);
        chk("ovf",     o_ovf,     m_ovf);
        if (e_gnt != 2'b00) chk("preg", o_preg, e_byp ? m_q[0] : m_fl[0]);
        if (e_we)           chk("fl_wdata", o_fl_wdata, m_q[0]);
    end

    // Model state update at the clock edge, using the decisions from the last compare.
    always @(posedge i_clk) begin
        if (!i_rst_n) begin
            model_reset();
        end else begin
            if (e_gnt != 2'b00) m_ptr = ~m_ptr;
            if (e_re) void'(m_fl.pop_front());
            if (e_we) m_fl.push_back(m_q[0]);
            if (e_we || e_byp) void'(m_q.pop_front());
            m_cnt = m_cnt + int'(e_we) - int'(e_re);
            if (e_rdy) begin
                if (i_rel_vld[0]) m_q.push_back(int'(i_rel_preg0));
                if (i_rel_vld[1]) m_q.push_back(int'(i_rel_preg1));
            end else if (i_rel_vld != 2'b00) begin
                m_ovf = 1'b1;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    logic [1:0]   s_gnt;
    logic [W-1:0] s_preg, s_wdata;
    logic         s_we, s_rdy, s_ovf, s_empty;
    logic [W:0]   s_count;

    task automatic step(input logic [1:0] req, input logic [1:0] vld,
                        input logic [W-1:0] p0, input logic [W-1:0] p1);
        i_req = req; i_rel_vld = vld; i_rel_preg0 = p0; i_rel_preg1 = p1;
        i_fl_rdata = (m_fl.size() > 0) ? W'(m_fl[0]) : '0;
        #2;
        s_gnt = o_gnt; s_preg = o_preg; s_we = o_fl_we; s_wdata = o_fl_wdata;
        s_rdy = o_rel_rdy; s_ovf = o_ovf; s_empty = o_empty; s_count = o_count;
        $display("t=%0t req=%b vld=%b gnt=%b preg=%0d we=%b wdata=%0d count=%0d rdy=%b ovf=%b",
                 $time, req, vld, s_gnt, s_preg, s_we, s_wdata, s_count, s_rdy, s_ovf);
        @(posedge i_clk); #1;
    endtask

    logic [1:0] g [4];

    initial begin
        i_rst_n = 1'b0; i_req = 2'b11; i_rel_vld = 2'b11;
        i_rel_preg0 = 5'd1; i_rel_preg1 = 5'd2; i_fl_rdata = '0;
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_count", o_count, 31);
        chk("rst_rdy",   o_rel_rdy, 1);
        chk("rst_gnt",   o_gnt, 2'b00);
        chk("rst_ovf",   o_ovf, 0);

        // Both lanes requesting: the grant alternates starting with lane 0.
        i_rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(2'b11, 2'b00, '0, '0);
            g[i] = s_gnt;
        end
        chk("rr_g0", g[0], 2'b01);
        chk("rr_g1", g[1], 2'b10);
        chk("rr_g2", g[2], 2'b01);
        chk("rr_g3", g[3], 2'b10);
        chk("rr_count", o_count, 27);

        // Drain down to one free register, take it, then see the list run dry.
        repeat (26) step(2'b01, 2'b00, '0, '0);
        step(2'b01, 2'b00, '0, '0);
        chk("last_gnt", s_gnt, 2'b01);
        step(2'b01, 2'b00, '0, '0);
        chk("dry_gnt",   s_gnt, 2'b00);
        chk("dry_empty", s_empty, 1);
        chk("dry_count", s_count, 0);

        // Empty list with register 9 staged; lane 1 requests.
        step(2'b00, 2'b01, 5'd9, '0);
        step(2'b10, 2'b00, '0, '0);
`ifdef PREG_ALLOC_BYPASS_EN
        chk("byp_gnt",  s_gnt, 2'b10);
        chk("byp_preg", s_preg, 9);
        step(2'b10, 2'b00, '0, '0);
        chk("byp_after", s_gnt, 2'b00);
`else
        chk("nobyp_gnt", s_gnt, 2'b00);
        chk("nobyp_we",  s_we, 1);
        step(2'b10, 2'b00, '0, '0);
        chk("nobyp_gnt2", s_gnt, 2'b10);
        chk("nobyp_preg", s_preg, 9);
`endif
        step(2'b00, 2'b00, '0, '0);

        // Refill the list with one release per cycle.
        for (int i = 1; i <= 31; i++) step(2'b00, 2'b01, W'(i), '0);
        repeat (2) step(2'b00, 2'b00, '0, '0);
        chk("full_count", o_count, 31);

        // A release into a full list is held until a grant makes room.
        step(2'b00, 2'b01, 5'd7, '0);
        step(2'b00, 2'b00, '0, '0);
        chk("hold_we", s_we, 0);
        step(2'b01, 2'b00, '0, '0);
        chk("hold_we2", s_we, 0);
        step(2'b00, 2'b00, '0, '0);
        chk("drain_we",    s_we, 1);
        chk("drain_wdata", s_wdata, 7);

        // Fill staging to 3 entries, then releases are dropped and the overflow flag sticks.
        step(2'b00, 2'b11, 5'd3, 5'd4);
        step(2'b00, 2'b01, 5'd5, '0);
        step(2'b00, 2'b11, 5'd20, 5'd21);
        chk("ovf_rdy", s_rdy, 0);
        step(2'b00, 2'b00, '0, '0);
        chk("ovf_set",  s_ovf, 1);
        chk("ovf_rdy2", s_rdy, 0);

        // Start draining, then reset in the middle of a drain cycle.
        step(2'b01, 2'b00, '0, '0);
        step(2'b01, 2'b00, '0, '0);
        i_req = 2'b01; i_rel_vld = 2'b00;
        i_fl_rdata = (m_fl.size() > 0) ? W'(m_fl[0]) : '0;
        #1;
        chk("pre_rst_we", o_fl_we, 1);
        i_rst_n = 1'b0;
        #1;
        chk("mid_rst_gnt",   o_gnt, 2'b00);
        chk("mid_rst_re",    o_fl_re, 0);
        chk("mid_rst_we",    o_fl_we, 0);
        chk("mid_rst_count", o_count, 31);
        chk("mid_rst_rdy",   o_rel_rdy, 1);
        chk("mid_rst_ovf",   o_ovf, 0);
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        step(2'b00, 2'b00, '0, '0);
        chk("post_rst_we",    s_we, 0);
        chk("post_rst_count", s_count, 31);
        step(2'b11, 2'b00, '0, '0);
        chk("post_rst_gnt", s_gnt, 2'b01);
        step(2'b11, 2'b00, '0, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
